// File: rtl/sram_burst_ctrl.sv
// Request front-end for a 256x8 single-port SRAM macro: accepts single/burst
// read and write commands and sequences registered macro strobes.
module sram_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              sram_men,
    output logic              sram_wen,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_WAIT  = 3'd1;
    localparam logic [2:0] WR_ISSUE = 3'd2;
    localparam logic [2:0] RD_ISSUE = 3'd3;
    localparam logic [2:0] RD_WAIT  = 3'd4;
    localparam logic [2:0] RD_OUT   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              sram_wen_q, sram_wen_d;
    logic              sram_ren_q, sram_ren_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_din_q, sram_din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              rdata_last_q, rdata_last_d;
    logic [ADDR_W-1:0] addr_inc;
    logic              last_beat;

    assign addr_inc  = addr_q + ADDR_W'(1);
    assign last_beat = (cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        // Strobes default low so each one lasts exactly a single cycle.
        sram_wen_d    = 1'b0;
        sram_ren_d    = 1'b0;
        sram_addr_d   = sram_addr_q;
        sram_din_d    = sram_din_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        rdata_last_d  = rdata_last_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = req_len;
                    if (req_we) begin
                        state_d = WR_WAIT;
                    end else begin
                        state_d     = RD_ISSUE;
                        sram_ren_d  = 1'b1;
                        sram_addr_d = req_addr;
                    end
                end
            end
            WR_WAIT: begin
                if (wdata_valid) begin
                    sram_wen_d  = 1'b1;
                    sram_din_d  = wdata;
                    sram_addr_d = addr_q;
                    state_d     = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    addr_d  = addr_inc;
                    state_d = WR_WAIT;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                // Macro output is valid now: one cycle after the sampled strobe.
                rdata_d       = sram_dout;
                rdata_valid_d = 1'b1;
                rdata_last_d  = last_beat;
                state_d       = RD_OUT;
            end
            RD_OUT: begin
                if (rdata_ready) begin
                    rdata_valid_d = 1'b0;
                    rdata_last_d  = 1'b0;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d       = cnt_q - LEN_W'(1);
                        addr_d      = addr_inc;
                        sram_ren_d  = 1'b1;
                        sram_addr_d = addr_inc;
                        state_d     = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            sram_wen_q    <= 1'b0;
            sram_ren_q    <= 1'b0;
            sram_addr_q   <= '0;
            sram_din_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            sram_wen_q    <= sram_wen_d;
            sram_ren_q    <= sram_ren_d;
            sram_addr_q   <= sram_addr_d;
            sram_din_q    <= sram_din_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign wdata_ready = (state_q == WR_WAIT);
    assign busy        = (state_q != IDLE);
    assign sram_wen    = sram_wen_q;
    assign sram_ren    = sram_ren_q;
    assign sram_men    = sram_wen_q | sram_ren_q;
    assign sram_addr   = sram_addr_q;
    assign sram_din    = sram_din_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural 256x8 macro model.
module tb_sram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_we = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [3:0] req_len = 4'h0;
    logic       wdata_valid = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rdata_ready = 1'b0;
    logic       req_ready, wdata_ready, rdata_valid, rdata_last, busy;
    logic [7:0] rdata;
    logic       sram_men, sram_wen, sram_ren;
    logic [7:0] sram_addr, sram_din;
    logic [7:0] sram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .busy(busy),
        .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Macro model plus strobe monitor
    logic [7:0]  mem [256];
    logic [15:0] wlog [$];
    int ren_cnt = 0, wen_bad = 0, ren_bad = 0, both_bad = 0, men_bad = 0;
    logic prev_wen = 1'b0, prev_ren = 1'b0;

    always @(posedge clk) begin
        if (sram_men && sram_wen) mem[sram_addr] <= sram_din;
        if (sram_men && sram_ren) sram_dout <= mem[sram_addr];
        if (sram_wen) wlog.push_back({sram_addr, sram_din});
        if (sram_ren) ren_cnt++;
        if (sram_wen && prev_wen) wen_bad++;
        if (sram_ren && prev_ren) ren_bad++;
        if (sram_wen && sram_ren) both_bad++;
        if (sram_men !== (sram_wen | sram_ren)) men_bad++;
        prev_wen = sram_wen;
        prev_ren = sram_ren;
    end

    task automatic do_write(input logic [7:0] a, input logic [3:0] len,
                            input logic [7:0] d [16], input bit gaps, input bit spam);
        int base, t, sbad;
        logic [7:0] ea;
        base = wlog.size();
        sbad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = len;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_req_ready got %b want 1", req_ready);
        end
        @(negedge clk);
        if (spam) begin req_we = 1'b0; req_addr = ~a; end
        else req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) repeat (i % 5) begin
                @(negedge clk);
                if (req_valid && req_ready) sbad++;
            end
            wdata_valid = 1'b1; wdata = d[i]; t = 0;
            while (!wdata_ready && t < 50) begin
                @(negedge clk); t++;
                if (req_valid && req_ready) sbad++;
            end
            if (t >= 50) begin
                errors++; checks++; $display("FAIL wr_timeout beat %0d", i);
                wdata_valid = 1'b0; req_valid = 1'b0; return;
            end
            @(negedge clk);
            wdata_valid = 1'b0;
            if (req_valid && req_ready) sbad++;
            if (i == int'(len)) req_valid = 1'b0;
        end
        t = 0;
        while (busy && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle busy got %b want 0", busy); end
        checks++;
        if (wlog.size() - base != int'(len) + 1) begin
            errors++;
            $display("FAIL wr_count got %0d want %0d", wlog.size() - base, int'(len) + 1);
            return;
        end
        for (int i = 0; i <= int'(len); i++) begin
            ea = a + 8'(i);
            checks++;
            if (wlog[base+i] !== {ea, d[i]}) begin
                errors++;
                $display("FAIL wr_beat%0d addr/din got %h want %h", i, wlog[base+i], {ea, d[i]});
            end
        end
        if (spam) begin
            checks++;
            if (sbad != 0) begin errors++; $display("FAIL wr_req_spam accepted %0d want 0", sbad); end
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len,
                           input logic [7:0] d [16], input int stall,
                           input bit ready_hi, input bit spam);
        int t, sbad, hbad, rc;
        logic [7:0] rd;
        sbad = 0;
        rdata_ready = ready_hi;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_req_ready got %b want 1", req_ready);
        end
        @(negedge clk);
        if (spam) begin req_we = 1'b1; req_addr = ~a; end
        else req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!rdata_valid && t < 50) begin
                @(negedge clk); t++;
                if (req_valid && req_ready) sbad++;
            end
            // Accept edge (or issue edge) -> valid is always 3 edges.
            checks++;
            if (t != 2) begin
                errors++; $display("FAIL rd_latency beat %0d got %0d want 3", i, t + 1);
                if (t >= 50) begin rdata_ready = 1'b0; req_valid = 1'b0; return; end
            end
            checks++;
            if (rdata !== d[i] || rdata_last !== (i == int'(len))) begin
                errors++;
                $display("FAIL rd_beat%0d data/last got %h/%b want %h/%b",
                         i, rdata, rdata_last, d[i], (i == int'(len)));
            end
            if (stall > 0) begin
                rd = rdata; rc = ren_cnt; hbad = 0;
                repeat (stall) begin
                    @(negedge clk);
                    if (rdata_valid !== 1'b1 || rdata !== rd || ren_cnt != rc) hbad++;
                end
                checks++;
                if (hbad != 0) begin
                    errors++; $display("FAIL rd_hold beat %0d unstable cycles %0d want 0", i, hbad);
                end
            end
            if (req_valid && req_ready) sbad++;
            if (i == int'(len)) req_valid = 1'b0;
            rdata_ready = 1'b1;
            @(negedge clk);
            rdata_ready = ready_hi;
        end
        rdata_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rdata_valid !== 1'b0) begin
            errors++; $display("FAIL rd_end busy/valid got %b/%b want 0/0", busy, rdata_valid);
        end
        if (spam) begin
            checks++;
            if (sbad != 0) begin errors++; $display("FAIL rd_req_spam accepted %0d want 0", sbad); end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({sram_men, sram_wen, sram_ren, sram_addr, sram_din, rdata,
             rdata_valid, rdata_last, busy, wdata_ready} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero sram %b%b%b %h %h rdata %h v%b l%b busy %b wr %b",
                               sram_men, sram_wen, sram_ren, sram_addr, sram_din, rdata,
                               rdata_valid, rdata_last, busy, wdata_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release ready/busy got %b/%b want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] d [16];
        foreach (d[i]) d[i] = 8'h00;
        d[0] = 8'hA5;
        do_write(8'h10, 4'd0, d, 1'b0, 1'b0);
        do_read(8'h10, 4'd0, d, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [7:0] d [16];
        foreach (d[i]) d[i] = 8'h00;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        do_write(8'hFE, 4'd3, d, 1'b0, 1'b0);
        do_read(8'hFE, 4'd3, d, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] d [16];
        foreach (d[i]) d[i] = 8'h00;
        d[0] = 8'h11; d[1] = 8'h22;
        do_read(8'hFE, 4'd1, d, 5, 1'b0, 1'b0);
    endtask

    task automatic test_wdata_stall();
        logic [7:0] d [16];
        foreach (d[i]) d[i] = 8'h5A ^ 8'(i * 37);
        do_write(8'h80, 4'd5, d, 1'b1, 1'b0);
        do_read(8'h80, 4'd5, d, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d [16];
        int t, wb;
        foreach (d[i]) d[i] = 8'hC0 + 8'(i);
        do_write(8'h20, 4'd7, d, 1'b0, 1'b0);
        wb = wlog.size();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20; req_len = 4'd7;
        @(negedge clk);
        req_valid = 1'b0; t = 0;
        while (!rdata_valid && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (rdata_valid !== 1'b1) begin errors++; $display("FAIL rstmid_rd_out valid got %b want 1", rdata_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sram_men, sram_wen, sram_ren, sram_addr, sram_din, rdata,
             rdata_valid, rdata_last, busy, wdata_ready} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got sram %b%b%b %h %h rdata %h v%b l%b busy %b wr %b",
                               sram_men, sram_wen, sram_ren, sram_addr, sram_din, rdata,
                               rdata_valid, rdata_last, busy, wdata_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_release ready/busy got %b/%b want 1/0", req_ready, busy);
        end
        checks++;
        if (wlog.size() != wb) begin
            errors++; $display("FAIL rstmid_no_write got %0d writes want 0", wlog.size() - wb);
        end
        do_read(8'h20, 4'd7, d, 0, 1'b1, 1'b0);
    endtask

    task automatic test_max_len();
        logic [7:0] d [16];
        foreach (d[i]) d[i] = 8'hF0 - 8'(i * 3);
        do_write(8'h40, 4'd15, d, 1'b0, 1'b1);
        do_read(8'h40, 4'd15, d, 0, 1'b1, 1'b1);
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (wen_bad != 0 || ren_bad != 0) begin
            errors++; $display("FAIL strobe_width long wen/ren got %0d/%0d want 0/0", wen_bad, ren_bad);
        end
        checks++;
        if (both_bad != 0 || men_bad != 0) begin
            errors++; $display("FAIL strobe_excl both/men got %0d/%0d want 0/0", both_bad, men_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_wdata_stall();
        test_reset_mid();
        test_max_len();
        test_strobe_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
